// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin front end for a single-port RAM with registered read data.
// Define RAM_CLEAR_EN to zero-fill the RAM after every reset before traffic is accepted.
`ifndef ADDR
`define ADDR 10
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

module ram_port_arbiter #(
   parameter int unsigned ADDR_W = `ADDR,
   parameter int unsigned DATA_W = `WIDTH
) (
   input  logic              clka,
   input  logic              rst_n,
   input  logic              a_req_valid,
   output logic              a_req_ready,
   input  logic              a_req_we,
   input  logic [ADDR_W-1:0] a_req_addr,
   input  logic [DATA_W-1:0] a_req_wdata,
   output logic              a_rsp_valid,
   output logic [DATA_W-1:0] a_rsp_rdata,
   input  logic              b_req_valid,
   output logic              b_req_ready,
   input  logic              b_req_we,
   input  logic [ADDR_W-1:0] b_req_addr,
   input  logic [DATA_W-1:0] b_req_wdata,
   output logic              b_rsp_valid,
   output logic [DATA_W-1:0] b_rsp_rdata,
   output logic              ram_ena,
   output logic              ram_wea,
   output logic [ADDR_W-1:0] ram_addra,
   output logic [DATA_W-1:0] ram_dina,
   input  logic [DATA_W-1:0] ram_douta,
   output logic              init_done
);

   logic              run;
   logic              sweep;
   logic [ADDR_W-1:0] sweep_addr;
   logic              gnt_a, gnt_b;
   logic              rr_q, rr_d;         // 0 = A has priority, 1 = B
   logic              rsp_q, rsp_d;
   logic              owner_q, owner_d;   // 0 = A, 1 = B

`ifdef RAM_CLEAR_EN
   typedef enum logic [0:0] {StInit, StRun} state_e;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StInit;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StInit: begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) state_d = StRun;
         end
         StRun: ;
         default: state_d = StInit;
      endcase
   end

   // Gated by rst_n so nothing is granted or driven while reset is held.
   assign run        = rst_n & (state_q == StRun);
   assign sweep      = rst_n & (state_q == StInit);
   assign sweep_addr = cnt_q;
   assign init_done  = (state_q == StRun);
`else
   assign run        = rst_n;
   assign sweep      = 1'b0;
   assign sweep_addr = '0;
   assign init_done  = 1'b1;
`endif

   always_comb begin
      gnt_a     = run & a_req_valid & (~b_req_valid | ~rr_q);
      gnt_b     = run & b_req_valid & (~a_req_valid | rr_q);
      ram_ena   = 1'b0;
      ram_wea   = 1'b0;
      ram_addra = '0;
      ram_dina  = '0;
      if (sweep) begin
         ram_ena   = 1'b1;
         ram_wea   = 1'b1;
         ram_addra = sweep_addr;
      end else if (gnt_a) begin
         ram_ena   = 1'b1;
         ram_wea   = a_req_we;
         ram_addra = a_req_addr;
         ram_dina  = a_req_wdata;
      end else if (gnt_b) begin
         ram_ena   = 1'b1;
         ram_wea   = b_req_we;
         ram_addra = b_req_addr;
         ram_dina  = b_req_wdata;
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (gnt_a)      rr_d = 1'b1;
      else if (gnt_b) rr_d = 1'b0;
      rsp_d   = (gnt_a & ~a_req_we) | (gnt_b & ~b_req_we);
      owner_d = gnt_b;
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         rr_q    <= 1'b0;
         rsp_q   <= 1'b0;
         owner_q <= 1'b0;
      end else begin
         rr_q    <= rr_d;
         rsp_q   <= rsp_d;
         owner_q <= owner_d;
      end
   end

   assign a_req_ready = gnt_a;
   assign b_req_ready = gnt_b;
   assign a_rsp_valid = rsp_q & ~owner_q;
   assign b_rsp_valid = rsp_q & owner_q;
   assign a_rsp_rdata = a_rsp_valid ? ram_douta : '0;
   assign b_rsp_rdata = b_rsp_valid ? ram_douta : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: reference arbiter model, shadow memory and RAM model.
// Follows the DUT configuration through RAM_CLEAR_EN.
module tb_ram_port_arbiter;
   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;
`ifdef RAM_CLEAR_EN
   localparam bit CLEAR = 1'b1;
`else
   localparam bit CLEAR = 1'b0;
`endif

   logic          clka = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_req_valid = 1'b0, a_req_we = 1'b0;
   logic [AW-1:0] a_req_addr = '0;
   logic [DW-1:0] a_req_wdata = '0;
   logic          b_req_valid = 1'b0, b_req_we = 1'b0;
   logic [AW-1:0] b_req_addr = '0;
   logic [DW-1:0] b_req_wdata = '0;
   logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
   logic [DW-1:0] a_rsp_rdata, b_rsp_rdata;
   logic          ram_ena, ram_wea, init_done;
   logic [AW-1:0] ram_addra;
   logic [DW-1:0] ram_dina, ram_douta;

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clka(clka), .rst_n(rst_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
      .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
      .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
      .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
      .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
      .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
      .ram_douta(ram_douta), .init_done(init_done)
   );

   always #5 clka = ~clka;

   // Single-port RAM with registered read, preloaded with a known pattern.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] shadow [DEPTH];
   always @(posedge clka) begin
      if (ram_ena) begin
         if (ram_wea) mem[ram_addra] <= ram_dina;
         else         ram_douta <= mem[ram_addra];
      end
   end

   typedef struct packed {
      logic          owner;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t sb[$];
   int   vectors = 0;
   int   errors  = 0;
   bit   rr_m    = 1'b0;
   bit   run_m   = 1'b0;
   int   init_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_a(input logic v, input logic we, input int addr, input int wd);
      a_req_valid = v; a_req_we = we; a_req_addr = AW'(addr); a_req_wdata = DW'(wd);
   endtask

   task automatic set_b(input logic v, input logic we, input int addr, input int wd);
      b_req_valid = v; b_req_we = we; b_req_addr = AW'(addr); b_req_wdata = DW'(wd);
   endtask

   task automatic accept(input logic owner, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
      rsp_t e;
      check(owner ? "b_ram_wea" : "a_ram_wea", ram_wea, we);
      check(owner ? "b_ram_addr" : "a_ram_addr", ram_addra, addr);
      if (we) begin
         check(owner ? "b_ram_dina" : "a_ram_dina", ram_dina, wd);
         shadow[addr] = wd;
      end else begin
         e.owner = owner;
         e.data  = shadow[addr];
         sb.push_back(e);
      end
      rr_m = ~owner;
   endtask

   // One clock: check responses and grants at the falling edge, then commit the model.
   task automatic step();
      rsp_t e;
      logic ga, gb;
      @(negedge clka);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("a_rsp_valid", a_rsp_valid, !e.owner);
         check("b_rsp_valid", b_rsp_valid, e.owner);
         check("rsp_rdata", e.owner ? b_rsp_rdata : a_rsp_rdata, e.data);
         check("idle_rdata", e.owner ? a_rsp_rdata : b_rsp_rdata, 0);
      end else begin
         check("no_rsp", {a_rsp_valid, b_rsp_valid}, 0);
      end
      check("init_done", init_done, run_m);
      if (!run_m) begin
         check("init_ready", {a_req_ready, b_req_ready}, 0);
         check("init_pins", {ram_ena, ram_wea, ram_dina}, {1'b1, 1'b1, {DW{1'b0}}});
         check("init_addr", ram_addra, init_cnt);
         shadow[init_cnt] = '0;
         init_cnt++;
         if (init_cnt == DEPTH) run_m = 1'b1;
      end else begin
         ga = a_req_valid & (!b_req_valid | !rr_m);
         gb = b_req_valid & (!a_req_valid | rr_m);
         check("a_req_ready", a_req_ready, ga);
         check("b_req_ready", b_req_ready, gb);
         check("ram_ena", ram_ena, ga | gb);
         if (ga)      accept(1'b0, a_req_we, a_req_addr, a_req_wdata);
         else if (gb) accept(1'b1, b_req_we, b_req_addr, b_req_wdata);
         else         check("idle_pins", {ram_wea, ram_addra, ram_dina}, 0);
      end
      @(posedge clka);
      #1;
   endtask

   task automatic idle();
      set_a(0, 0, 0, 0);
      set_b(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      set_a(1, 0, 1, 0);
      set_b(1, 1, 2, 3);
      rst_n = 1'b0;
      #2;
      check("rst_ready", {a_req_ready, b_req_ready}, 0);
      check("rst_rsp", {a_rsp_valid, b_rsp_valid, a_rsp_rdata, b_rsp_rdata}, 0);
      check("rst_ram", {ram_ena, ram_wea, ram_addra, ram_dina}, 0);
      check("rst_init_done", init_done, !CLEAR);
      @(posedge clka);
      #1;
      idle();
      rst_n    = 1'b1;
      rr_m     = 1'b0;
      run_m    = !CLEAR;
      init_cnt = 0;
      sb.delete();
   endtask

   task automatic sweep();
      while (!run_m) step();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]    = DW'(i ^ 8'h5A);
         shadow[i] = DW'(i ^ 8'h5A);
      end
      do_reset();
      sweep();
      // First cycle: A reads address 0 (preload, or zero after a sweep).
      set_a(1, 0, 0, 0);
      step();
      set_a(1, 0, 5, 0);
      step();
      idle();
      step();
      // A writes 0x3C to 7, B reads it back on the next cycle.
      set_a(1, 1, 7, 8'h3C);
      step();
      set_a(0, 0, 0, 0);
      set_b(1, 0, 7, 0);
      step();
      idle();
      step();
      // Both requesters reading from reset: A,B,A,B,A,B.
      do_reset();
      sweep();
      for (int i = 0; i < 6; i++) begin
         set_a(1, 0, 16 + i, 0);
         set_b(1, 0, 32 + i, 0);
         step();
      end
      idle();
      step();
      // B alone for three cycles, then both: A wins, then B.
      for (int i = 0; i < 3; i++) begin
         set_b(1, 0, 40 + i, 0);
         step();
      end
      set_a(1, 0, 50, 0);
      set_b(1, 0, 51, 0);
      step();
      step();
      idle();
      step();
      // Random mixed traffic on a small address window.
      for (int i = 0; i < 300; i++) begin
         set_a($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
               $urandom_range(0, 255));
         set_b($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
               $urandom_range(0, 255));
         step();
      end
      idle();
      step();
      // Reset asserted in the cycle a read is being accepted.
      set_a(1, 0, 3, 0);
      @(negedge clka);
      check("pre_rst_ready", a_req_ready, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", {a_req_ready, b_req_ready}, 0);
      check("mid_rst_rsp", {a_rsp_valid, b_rsp_valid}, 0);
      @(posedge clka);
      #1;
      idle();
      rst_n    = 1'b1;
      rr_m     = 1'b0;
      run_m    = !CLEAR;
      init_cnt = 0;
      sb.delete();
      step();
      sweep();
      set_b(1, 0, 7, 0);
      step();
      idle();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester front end for the single-port RAM macro: it arbitrates per cycle between requesters A and B, drives the RAM's enable, write-enable, address and data pins, and returns read data to the requester that issued the read. It sits directly in front of the RAM instance. When compiled in, it also runs a post-reset zero-fill sweep so the RAM contents are deterministic before traffic starts.

## Interface
Parameters:
- ADDR_W, default `ADDR (10): RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, default `WIDTH: RAM word width.

Ports:
- clka  in  1  sole clock; RAM shares it.
- rst_n  in  1  reset, asynchronous assert, active-low.
- a_req_valid  in  1  requester A has a request.
- a_req_ready  out  1  A's request is accepted this cycle.
- a_req_we  in  1  1 = write, 0 = read.
- a_req_addr  in  ADDR_W  request address.
- a_req_wdata  in  DATA_W  write data.
- a_rsp_valid  out  1  read data for A on a_rsp_rdata this cycle.
- a_rsp_rdata  out  DATA_W  read data.
- b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata: same as the A ports, for requester B.
- ram_ena  out  1  RAM enable.
- ram_wea  out  1  RAM write enable.
- ram_addra  out  ADDR_W  RAM address.
- ram_dina  out  DATA_W  RAM write data.
- ram_douta  in  DATA_W  RAM registered read data.
- init_done  out  1  high once the block is in RUN.

## Operation
- FSM states: INIT and RUN.
  - Reset enters INIT when RAM_CLEAR_EN is defined, otherwise RUN.
  - INIT moves to RUN after the sweep completes.
  - RUN is terminal until the next reset.
- In RUN, the grant is combinational from the valids and the round-robin pointer rr:
  - Only one valid: that requester wins.
  - Both valid: the requester indicated by rr wins.
  - x_req_ready = grant to x. A ready never depends on the same requester's ready.
- Pointer update: after each accepted request, rr points to the other requester. With no acceptance, rr holds.
- RAM drive:
  - ram_ena = any grant.
  - ram_wea, ram_addra, ram_dina are muxed from the winner.
  - With no grant, all RAM outputs are 0.
- Writes complete on acceptance and produce no response.
- Reads:
  - A registered 1-bit owner tag and a registered rsp flag capture the accepted read.
  - The next cycle, that owner's x_rsp_valid = 1 and x_rsp_rdata = ram_douta.
  - The other requester's rsp_rdata reads 0.
- There is no response backpressure. Requesters must sink responses.
- The loser keeps its valid asserted and is served next, so there is no starvation.

## Timing
- Reset values:
  - ready both 0, rsp_valid both 0, rsp_rdata both 0.
  - ram_ena/ram_wea/ram_addra/ram_dina 0.
  - rr = A.
  - init_done = 0 if RAM_CLEAR_EN is defined, else 1.
- Accepted read at edge T: ram pins are presented in the cycle before T. x_rsp_valid is high for exactly the cycle after T. Read latency is 1 cycle.
- Back-to-back reads: one per cycle, responses in order. Alternating owners are allowed on consecutive cycles.
- Read and write to the same address on consecutive cycles: the read returns whatever the RAM returns for its collision mode. The arbiter adds no forwarding.
- Reset mid-operation:
  - Any pending response is dropped; rsp_valid goes to 0 immediately.
  - The sweep restarts from address 0.
  - rr returns to A.

## Configuration
- RAM_CLEAR_EN defined:
  - INIT holds both readies at 0.
  - INIT drives ram_ena = 1, ram_wea = 1, ram_dina = 0, with ram_addra counting 0..DEPTH-1, one word per cycle.
  - After writing DEPTH-1 the block enters RUN, and init_done rises the next cycle (DEPTH cycles after reset release).
  - Requests issued during INIT are ignored but not lost: valid stays pending.
- RAM_CLEAR_EN undefined:
  - No INIT state and no sweep counter; the block starts in RUN.
  - init_done is tied to 1.
  - RAM keeps its preloaded contents.

## Test plan
- Reset release with RAM_CLEAR_EN and ADDR_W=10: init_done rises after 1024 cycles; ram_addra walks 0..1023 with wea=1 and dina=0. A read of address 5 afterwards returns 0.
- A writes 0x3C to addr 7, then B reads addr 7 on the next cycle: B ready=1, b_rsp_valid one cycle later, b_rsp_rdata=0x3C, a_rsp_valid stays 0.
- A and B both valid reading for 6 cycles from reset: grants go A,B,A,B,A,B. Each rsp_valid appears 1 cycle after its grant with the correct data.
- Only B valid for 3 cycles, then both valid: B, B, B, then A wins (rr points to A after B's grant), then B.
- rst_n pulsed low on the cycle a read is accepted: no rsp_valid follows, readies 0 during reset, and the sweep restarts at address 0.
- Without RAM_CLEAR_EN: init_done=1 and A is granted in the first cycle after reset. A read of addr 0 returns the preloaded word.
